poc_exec_unit: RTL and testbench
================================

# poc_exec_unit

Parametrised execution unit for the PoC processor. It replaces the fixed set of named 18-bit scratch registers, the ALU operand muxes, the ALU and AC with one block containing:

- a `NUM_REGS`-entry register file,
- a generalised ALU with an immediate operand,
- a handshaked, wait-state-tolerant data-memory port with timeout.

The control unit issues one command per valid/ready handshake. The block executes ALU commands in one cycle and memory commands over a variable number of cycles.

## Interface

Parameters:

- `DATA_W`, 18, register, AC, ALU and memory data width
- `ADDR_W`, 16, memory address width; address is the low `ADDR_W` bits of the computed sum
- `NUM_REGS`, 8, register file depth; power of two, at least 2; `RIDX_W = $clog2(NUM_REGS)`
- `MEM_TIMEOUT`, 255, maximum cycles `mem_req` waits for `mem_ack`; 0 disables the timeout

Ports:

- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock
  - `rst`  in  1  synchronous active-high reset
- Command handshake:
  - `cmd_valid`  in  1  command present
  - `cmd_ready`  out  1  block can accept a command
  - `cmd_kind`  in  2  0 ALU, 1 LOAD, 2 STORE, 3 NOP
- Command fields:
  - `cmd_alu_op`  in  4  ALU operation code
  - `cmd_src_a`  in  `RIDX_W`  operand A register index
  - `cmd_b_imm`  in  1  1: B = `cmd_imm`, 0: B = AC
  - `cmd_imm`  in  `DATA_W`  immediate value / address offset
  - `cmd_dst`  in  `RIDX_W`  destination register index
  - `cmd_wr_reg`  in  1  ALU result written to `R[cmd_dst]`
  - `cmd_wr_ac`  in  1  ALU result written to AC
- Completion:
  - `done`  out  1  one-cycle completion pulse
- Memory port:
  - `mem_req`  out  1  memory request
  - `mem_we`  out  1  1 store, 0 load
  - `mem_addr`  out  `ADDR_W`  memory address
  - `mem_wdata`  out  `DATA_W`  store data
  - `mem_ack`  in  1  memory acknowledge
  - `mem_rdata`  in  `DATA_W`  load data, valid with `mem_ack`
- Status:
  - `ac`  out  `DATA_W`  accumulator
  - `zero`, `neg`, `lsb`  out  1 each  ALU flags
  - `err`  out  1  sticky memory-timeout error

## Operation

- States:
  - IDLE: `cmd_ready` = 1.
  - MEM: `cmd_ready` = 0 and `mem_req` = 1.
- A command is accepted on a clock edge where `cmd_valid && cmd_ready`.
- ALU opcodes:
  - 0 PASS_A, 1 PASS_B, 2 ADD (A+B), 3 SUB (A−B), 4 MUL (low `DATA_W` bits)
  - 5 SHR1 (A>>1, logical), 6 SHL1 (A<<1), 7 INC (A+1), 8 DEC (A−1)
  - 9 AND, 10 OR, 11 CLR (0)
  - 12–15 behave as PASS_A
  - All arithmetic wraps modulo 2^`DATA_W`.
- ALU command:
  - The result is computed from current register and AC values.
  - At the accept edge, the result is written to `R[cmd_dst]` if `cmd_wr_reg` and to AC if `cmd_wr_ac`.
  - Flags update at the same edge: `zero` = (result == 0), `neg` = result MSB, `lsb` = result bit 0.
  - State stays IDLE.
  - `dst == src_a` is legal: A reads the old value.
- LOAD / STORE:
  - At accept, the block latches `mem_addr` = (`R[cmd_src_a]` + `cmd_imm`)[`ADDR_W`-1:0] and `mem_we`.
  - STORE also latches `mem_wdata` = AC.
  - LOAD also latches the destination index.
  - State goes to MEM. Flags and AC are unchanged by memory commands.
- In MEM:
  - On the edge where `mem_ack` = 1, a LOAD writes `mem_rdata` into the latched destination.
  - State then returns to IDLE.
- Timeout:
  - In MEM, a wait counter counts cycles with `mem_req` high and no ack.
  - When it reaches `MEM_TIMEOUT` (nonzero), `err` is set, `mem_req` drops, nothing is written, and state returns to IDLE.
  - `err` is cleared only by `rst`.
- NOP: accepted, `done` pulses, no other state change.
- `mem_ack` while in IDLE is ignored.

## Timing

- Reset values:
  - `cmd_ready` = 1
  - `done`, `mem_req`, `mem_we` = 0
  - `mem_addr`, `mem_wdata` = 0
  - `ac` = 0, all registers = 0
  - `zero` = 1, `neg` = 0, `lsb` = 0, `err` = 0
  - State IDLE
- ALU and NOP:
  - Single-cycle; results are visible in the cycle after the accept edge.
  - `done` is high in that cycle.
  - Back-to-back commands are accepted every cycle.
- LOAD / STORE:
  - `mem_req` rises in the cycle after accept.
  - Address, data and `mem_we` are stable while `mem_req` is high.
  - An ack in the first request cycle completes the command: 2 cycles from accept to `done`.
  - `done` is high in the cycle after the ack edge, or after the timeout edge, and `cmd_ready` is 1 again in that same cycle.
- Reset mid-MEM: `mem_req` is 0 in the cycle after the reset edge. A late `mem_ack` is ignored and no register is written.

## Structure

- Package `poc_exec_pkg` holds:
  - the ALU opcode localparams,
  - the `cmd_kind` encodings,
  - the state enum (IDLE, MEM).
- Sub-module `poc_exec_alu`: purely combinational; inputs `a`, `b`, `op`; outputs `result` and the three flags; parametrised by `DATA_W`.
- Register file, AC, flags, memory FSM and timeout counter live in `poc_exec_unit`.

## Test plan

- **Add/sub and zero flag.** After reset: ADD src_a=R0, b_imm=1, imm=5, dst=R1, wr_reg → R1=5, `zero`=0, `done` pulse one cycle later. Then SUB src_a=R1, imm=5, wr_ac → AC=0, `zero`=1.
- **Wrap-around.** PASS_B imm=0x3FFFF into R2, then INC R2 into R2 → R2=0, `zero`=1, `neg`=0; back-to-back, with `cmd_ready` held 1.
- **LOAD with wait states.** R1=0x10, LOAD src_a=R1, imm=4, dst=R3; `mem_ack` asserted on the 3rd request cycle with `mem_rdata`=0x2A → `mem_addr`=0x14, `mem_we`=0, R3=0x2A, `cmd_ready` low 3 cycles, then `done`.
- **STORE with immediate ack.** AC=7, STORE src_a=R0, imm=0x20, ack on the first request cycle → `mem_we`=1, `mem_wdata`=7, `mem_addr`=0x20, `done` 2 cycles after accept, flags unchanged.
- **Timeout.** `MEM_TIMEOUT`=4, LOAD with no ack → `mem_req` high exactly 4 cycles, `err`=1 and sticky, destination unchanged, next ALU command still executes.
- **Reset mid-MEM.** Assert `rst` during the 2nd request cycle, then ack → `mem_req`=0 after the reset edge, destination stays 0, `err`=0, `cmd_ready`=1.

Source files
------------

// File: rtl/poc_exec_pkg.sv
// Shared encodings for the PoC execution unit: ALU opcodes, command kinds
// and the memory-port state type.
package poc_exec_pkg;

  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_PASS_B = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_SUB    = 4'd3;
  localparam logic [3:0] ALU_MUL    = 4'd4;
  localparam logic [3:0] ALU_SHR1   = 4'd5;
  localparam logic [3:0] ALU_SHL1   = 4'd6;
  localparam logic [3:0] ALU_INC    = 4'd7;
  localparam logic [3:0] ALU_DEC    = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_OR     = 4'd10;
  localparam logic [3:0] ALU_CLR    = 4'd11;

  localparam logic [1:0] KIND_ALU   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_NOP   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_t;

endpackage

// File: rtl/poc_exec_alu.sv
// Combinational ALU of the PoC execution unit; all arithmetic wraps modulo
// 2^DATA_W and the flags describe the result.
module poc_exec_alu
  import poc_exec_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              lsb
);

  // Opcodes 12-15 are reserved and fall through to PASS_A.
  always_comb begin
    result = a;
    case (op)
      ALU_PASS_A: result = a;
      ALU_PASS_B: result = b;
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_MUL:    result = a * b;
      ALU_SHR1:   result = a >> 1;
      ALU_SHL1:   result = a << 1;
      ALU_INC:    result = a + DATA_W'(1);
      ALU_DEC:    result = a - DATA_W'(1);
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_CLR:    result = '0;
      default:    result = a;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DATA_W-1];
  assign lsb  = result[0];

endmodule

// File: rtl/poc_exec_unit.sv
// PoC execution unit: register file, accumulator, ALU flags and a handshaked
// data-memory port with an optional request timeout.
module poc_exec_unit
  import poc_exec_pkg::*;
#(
  parameter int DATA_W      = 18,
  parameter int ADDR_W      = 16,
  parameter int NUM_REGS    = 8,
  parameter int MEM_TIMEOUT = 255,
  localparam int RIDX_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [3:0]        cmd_alu_op,
  input  logic [RIDX_W-1:0] cmd_src_a,
  input  logic              cmd_b_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [RIDX_W-1:0] cmd_dst,
  input  logic              cmd_wr_reg,
  input  logic              cmd_wr_ac,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ac,
  output logic              zero,
  output logic              neg,
  output logic              lsb,
  output logic              err
);

  // The wait counter only has to reach MEM_TIMEOUT-1; the timeout fires on
  // the edge that would otherwise start request cycle MEM_TIMEOUT+1.
  localparam int CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [RIDX_W-1:0]   load_dst;
  logic [CNT_W-1:0]    wait_cnt;

  logic [DATA_W-1:0]   opnd_a;
  logic [DATA_W-1:0]   opnd_b;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                alu_neg;
  logic                alu_lsb;
  logic [DATA_W-1:0]   addr_sum;
  logic                timeout_hit;

  assign opnd_a   = regs[cmd_src_a];
  assign opnd_b   = cmd_b_imm ? cmd_imm : ac;
  assign addr_sum = opnd_a + cmd_imm;

  assign cmd_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_MEM);

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST));

  poc_exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (opnd_a),
    .b      (opnd_b),
    .op     (cmd_alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .lsb    (alu_lsb)
  );

  // Register file, accumulator and flags change only on ALU accepts or on a
  // LOAD ack; the memory address/data/direction are held for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_dst  <= '0;
      wait_cnt  <= '0;
      ac        <= '0;
      zero      <= 1'b1;
      neg       <= 1'b0;
      lsb       <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_kind)
              KIND_ALU: begin
                if (cmd_wr_reg) begin
                  regs[cmd_dst] <= alu_result;
                end
                if (cmd_wr_ac) begin
                  ac <= alu_result;
                end
                zero <= alu_zero;
                neg  <= alu_neg;
                lsb  <= alu_lsb;
                done <= 1'b1;
              end
              KIND_LOAD, KIND_STORE: begin
                mem_addr <= ADDR_W'(addr_sum);
                mem_we   <= (cmd_kind == KIND_STORE);
                if (cmd_kind == KIND_STORE) begin
                  mem_wdata <= ac;
                end else begin
                  load_dst <= cmd_dst;
                end
                wait_cnt <= '0;
                state    <= ST_MEM;
              end
              default: begin
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!mem_we) begin
              regs[load_dst] <= mem_rdata;
            end
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poc_exec_unit.sv
// Self-checking bench for poc_exec_unit: directed scenarios plus random
// commands compared against an arithmetic reference model.
module tb_poc_exec_unit;

  localparam int DW = 18;
  localparam int AW = 16;
  localparam int NR = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_kind;
  logic [3:0]    cmd_alu_op;
  logic [2:0]    cmd_src_a;
  logic          cmd_b_imm;
  logic [DW-1:0] cmd_imm;
  logic [2:0]    cmd_dst;
  logic          cmd_wr_reg;
  logic          cmd_wr_ac;
  logic          done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ac;
  logic          zero;
  logic          neg;
  logic          lsb;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_ac;
  logic          m_zero;
  logic          m_neg;
  logic          m_lsb;
  logic          m_err;

  always #5 clk = ~clk;

  poc_exec_unit #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .NUM_REGS    (NR),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_alu_op (cmd_alu_op),
    .cmd_src_a  (cmd_src_a),
    .cmd_b_imm  (cmd_b_imm),
    .cmd_imm    (cmd_imm),
    .cmd_dst    (cmd_dst),
    .cmd_wr_reg (cmd_wr_reg),
    .cmd_wr_ac  (cmd_wr_ac),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ac         (ac),
    .zero       (zero),
    .neg        (neg),
    .lsb        (lsb),
    .err        (err)
  );

  function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint la, lb, m, r;
    la = longint'(a);
    lb = longint'(b);
    m  = longint'(1) << DW;
    case (op)
      1:       r = lb;
      2:       r = (la + lb) % m;
      3:       r = (la - lb + m) % m;
      4:       r = (la * lb) % m;
      5:       r = la / 2;
      6:       r = (la * 2) % m;
      7:       r = (la + 1) % m;
      8:       r = (la - 1 + m) % m;
      9:       r = longint'(a & b);
      10:      r = longint'(a | b);
      11:      r = 0;
      default: r = la;
    endcase
    return DW'(r);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ac = '0;
    m_zero = 1'b1;
    m_neg = 1'b0;
    m_lsb = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic run_alu(input int op, input int src, input logic b_imm, input logic [DW-1:0] imm,
                         input int dst, input logic wr_reg, input logic wr_ac, input string tag);
    logic [DW-1:0] res;
    res = ref_alu(op, m_regs[src], b_imm ? imm : m_ac);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_before: got %0b expected 1", tag, cmd_ready);
    end
    cmd_kind = 2'd0; cmd_alu_op = 4'(op); cmd_src_a = 3'(src); cmd_b_imm = b_imm;
    cmd_imm = imm; cmd_dst = 3'(dst); cmd_wr_reg = wr_reg; cmd_wr_ac = wr_ac;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wr_reg) m_regs[dst] = res;
    if (wr_ac) m_ac = res;
    m_zero = (res == 0);
    m_neg = (res >= (DW'(1) << (DW - 1)));
    m_lsb = (res % 2) == 1;
    checks += 5;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done: got %0b expected 1", tag, done);
    end
    if (ac !== m_ac) begin
      errors++;
      $display("[TB] FAIL %s ac: got %h expected %h", tag, ac, m_ac);
    end
    if ({zero, neg, lsb} !== {m_zero, m_neg, m_lsb}) begin
      errors++;
      $display("[TB] FAIL %s flags: got %b expected %b", tag, {zero, neg, lsb}, {m_zero, m_neg, m_lsb});
    end
    if (dut.regs[dst] !== m_regs[dst]) begin
      errors++;
      $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, dst, dut.regs[dst], m_regs[dst]);
    end
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_after: got %0b expected 1", tag, cmd_ready);
    end
  endtask

  // ack_at: request cycle (1-based) in which mem_ack is raised; 0 means never
  task automatic run_mem(input logic store, input int src, input logic [DW-1:0] imm, input int dst,
                         input int ack_at, input logic [DW-1:0] rdata, input string tag);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int req_cycles;
    int exp_cycles;
    bit finished;
    bit acked;
    exp_addr = AW'((longint'(m_regs[src]) + longint'(imm)) % (longint'(1) << AW));
    exp_wdata = m_ac;
    acked = (ack_at >= 1) && (ack_at <= TO);
    exp_cycles = acked ? ack_at : TO;
    cmd_kind = store ? 2'd2 : 2'd1; cmd_alu_op = 4'd0; cmd_src_a = 3'(src); cmd_b_imm = 1'b1;
    cmd_imm = imm; cmd_dst = 3'(dst); cmd_wr_reg = 1'b0; cmd_wr_ac = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    req_cycles = 0;
    finished = 1'b0;
    for (int c = 1; c <= 3 * TO + 4 && !finished; c++) begin
      if (mem_req === 1'b1) begin
        req_cycles++;
        checks += 3;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("[TB] FAIL %s addr c%0d: got %h expected %h", tag, c, mem_addr, exp_addr);
        end
        if (mem_we !== store) begin
          errors++;
          $display("[TB] FAIL %s we c%0d: got %0b expected %0b", tag, c, mem_we, store);
        end
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s ready_busy c%0d: got %0b expected 0", tag, c, cmd_ready);
        end
        if (store) begin
          checks++;
          if (mem_wdata !== exp_wdata) begin
            errors++;
            $display("[TB] FAIL %s wdata c%0d: got %h expected %h", tag, c, mem_wdata, exp_wdata);
          end
        end
        if (c == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end else begin
        finished = 1'b1;
      end
    end
    if (acked && !store) m_regs[dst] = rdata;
    if (!acked) m_err = 1'b1;
    checks += 7;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL %s mem_req_stuck: got high after %0d cycles expected low", tag, req_cycles);
    end
    if (req_cycles != exp_cycles) begin
      errors++;
      $display("[TB] FAIL %s req_cycles: got %0d expected %0d", tag, req_cycles, exp_cycles);
    end
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done/ready: got %0b/%0b expected 1/1", tag, done, cmd_ready);
    end
    if (dut.regs[dst] !== m_regs[dst]) begin
      errors++;
      $display("[TB] FAIL %s reg%0d: got %h expected %h", tag, dst, dut.regs[dst], m_regs[dst]);
    end
    if (err !== m_err) begin
      errors++;
      $display("[TB] FAIL %s err: got %0b expected %0b", tag, err, m_err);
    end
    if (ac !== m_ac) begin
      errors++;
      $display("[TB] FAIL %s ac: got %h expected %h", tag, ac, m_ac);
    end
    if ({zero, neg, lsb} !== {m_zero, m_neg, m_lsb}) begin
      errors++;
      $display("[TB] FAIL %s flags: got %b expected %b", tag, {zero, neg, lsb}, {m_zero, m_neg, m_lsb});
    end
  endtask

  task automatic run_nop(input string tag);
    cmd_kind = 2'd3; cmd_alu_op = 4'd11; cmd_wr_reg = 1'b1; cmd_wr_ac = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks += 3;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done: got %0b expected 1", tag, done);
    end
    if (ac !== m_ac) begin
      errors++;
      $display("[TB] FAIL %s ac: got %h expected %h", tag, ac, m_ac);
    end
    if (dut.regs[cmd_dst] !== m_regs[cmd_dst]) begin
      errors++;
      $display("[TB] FAIL %s reg: got %h expected %h", tag, dut.regs[cmd_dst], m_regs[cmd_dst]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if ({cmd_ready, done, mem_req, mem_we} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset ctrl: got %b expected 1000", {cmd_ready, done, mem_req, mem_we});
    end
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset mem: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    if (ac !== '0 || {zero, neg, lsb, err} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset status: got ac=%h flags=%b expected 0/1000", ac, {zero, neg, lsb, err});
    end
    for (int i = 0; i < NR; i++) begin
      if (dut.regs[i] !== '0) begin
        errors++;
        $display("[TB] FAIL reset reg%0d: got %h expected 0", i, dut.regs[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    run_alu(2, 0, 1'b1, 18'd5, 1, 1'b1, 1'b0, "add");
    run_alu(3, 1, 1'b1, 18'd5, 0, 1'b0, 1'b1, "sub");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: got %0b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    run_alu(1, 0, 1'b1, 18'h3FFFF, 2, 1'b1, 1'b0, "wrap_pass");
    run_alu(7, 2, 1'b1, 18'h0, 2, 1'b1, 1'b0, "wrap_inc");
    run_alu(8, 2, 1'b1, 18'h0, 3, 1'b1, 1'b1, "wrap_dec");
  endtask

  task automatic test_load_wait();
    run_alu(1, 0, 1'b1, 18'h10, 1, 1'b1, 1'b0, "ld_setup");
    run_mem(1'b0, 1, 18'd4, 3, 3, 18'h2A, "load_wait");
  endtask

  task automatic test_store_imm();
    run_alu(1, 0, 1'b1, 18'd7, 0, 1'b0, 1'b1, "st_setup");
    run_mem(1'b1, 0, 18'h20, 0, 1, 18'h0, "store_imm");
  endtask

  task automatic test_timeout();
    run_alu(1, 0, 1'b1, 18'h155, 5, 1'b1, 1'b0, "to_setup");
    run_mem(1'b0, 0, 18'h40, 5, 0, 18'h0, "timeout");
    run_alu(2, 5, 1'b1, 18'd1, 6, 1'b1, 1'b0, "after_to");
    run_nop("nop_err_sticky");
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    cmd_kind = 2'd1; cmd_src_a = 3'd0; cmd_imm = 18'h8; cmd_dst = 3'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 18'h1234;
    checks += 2;
    if (mem_req !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid req/ready: got %0b/%0b expected 0/1", mem_req, cmd_ready);
    end
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid err: got %0b expected 0", err);
    end
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    checks += 2;
    if (dut.regs[4] !== 18'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid reg4: got %h expected 0", dut.regs[4]);
    end
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid done/req: got %0b/%0b expected 0/0", done, mem_req);
    end
  endtask

  task automatic test_idle_ack();
    mem_ack = 1'b1;
    mem_rdata = 18'h3ABCD;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checks += 2;
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ack done/req: got %0b/%0b expected 0/0", done, mem_req);
    end
    if (dut.regs[0] !== m_regs[0] || dut.regs[4] !== m_regs[4]) begin
      errors++;
      $display("[TB] FAIL idle_ack regs: got %h/%h expected %h/%h", dut.regs[0], dut.regs[4], m_regs[0], m_regs[4]);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      if (kind <= 2) begin
        run_alu($urandom_range(0, 15), $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                DW'($urandom), $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "rand_alu");
      end else if (kind == 3) begin
        run_mem(1'b0, $urandom_range(0, NR - 1), DW'($urandom), $urandom_range(0, NR - 1),
                $urandom_range(0, TO + 1), DW'($urandom), "rand_load");
      end else if (kind == 4) begin
        run_mem(1'b1, $urandom_range(0, NR - 1), DW'($urandom), 0,
                $urandom_range(1, TO), DW'($urandom), "rand_store");
      end else begin
        cmd_dst = 3'($urandom_range(0, NR - 1));
        run_nop("rand_nop");
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd3; cmd_alu_op = 4'd0; cmd_src_a = 3'd0;
    cmd_b_imm = 1'b0; cmd_imm = '0; cmd_dst = 3'd0; cmd_wr_reg = 1'b0; cmd_wr_ac = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_wrap();
    test_load_wait();
    test_store_imm();
    test_timeout();
    test_reset_mid_mem();
    test_idle_ack();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
